// File: rtl/sd_fifo_rx_emptier.sv
// sd_fifo_rx_emptier: receive-side DMA engine for the SD data path.
// Buffers 32-bit words from the data-serial receiver in a small FIFO and
// drains them to memory as Wishbone single write cycles at consecutive
// addresses starting at adr.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_wb_*            Wishbone master write port (adr/dat/sel/we/cyc/stb, ack)
//   en                1 = transfer active, 0 = abort / flush / clear
//   adr               memory base address, stable while en = 1
//   wr, dat_i         serial-side push strobe and data word
//   full, empty       FIFO occupancy flags (registered)
//   count             FIFO occupancy, 0 .. 2^FIFO_AW (registered)
//   overflow          sticky: a push was dropped because the FIFO was full
module sd_fifo_rx_emptier #(
   parameter int unsigned FIFO_AW    = 4,
   parameter int unsigned MEM_OFFSET = 4,
   parameter int unsigned OFS_W      = 9
) (
   input  logic               clk,
   input  logic               rst,
   output logic [31:0]        m_wb_adr_o,
   output logic [31:0]        m_wb_dat_o,
   output logic [3:0]         m_wb_sel_o,
   output logic               m_wb_we_o,
   output logic               m_wb_cyc_o,
   output logic               m_wb_stb_o,
   input  logic               m_wb_ack_i,
   input  logic               en,
   input  logic [31:0]        adr,
   input  logic               wr,
   input  logic [31:0]        dat_i,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   count,
   output logic               overflow
);

   localparam int unsigned       DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [OFS_W-1:0]  OFS_STEP = OFS_W'(MEM_OFFSET);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic                  cyc;
   logic [OFS_W-1:0]      ofs;
   logic [31:0]           mem [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr;
   logic [FIFO_AW-1:0]    rd_ptr;
   logic                  pop_c;
   logic                  push_c;
   logic [FIFO_AW:0]      count_nxt_c;

   // A pop frees a slot in the same cycle, so a push at full is accepted then.
   assign pop_c  = en && (state == REQ) && m_wb_ack_i;
   assign push_c = en && wr && (!full || pop_c);

   always_comb begin
      count_nxt_c = count;
      if (push_c && !pop_c)
         count_nxt_c = count + (FIFO_AW+1)'(1);
      else if (pop_c && !push_c)
         count_nxt_c = count - (FIFO_AW+1)'(1);
   end

   // FIFO storage; contents need no reset, pointers/flags define validity.
   always_ff @(posedge clk) begin
      if (push_c)
         mem[wr_ptr] <= dat_i;
   end

   // FIFO pointers, occupancy flags and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else if (!en) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push_c)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop_c)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         count <= count_nxt_c;
         empty <= (count_nxt_c == '0);
         full  <= (count_nxt_c == FULL_CNT);
         if (wr && full && !pop_c)
            overflow <= 1'b1;
      end
   end

   // Bus master FSM: one single write per FIFO word, one idle cycle after each.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cyc        <= 1'b0;
         ofs        <= '0;
         m_wb_dat_o <= '0;
      end else if (!en) begin
         state <= IDLE;
         cyc   <= 1'b0;
         ofs   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  m_wb_dat_o <= mem[rd_ptr];
                  cyc        <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (m_wb_ack_i) begin
                  cyc   <= 1'b0;
                  ofs   <= ofs + OFS_STEP;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               cyc   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Offset wraps naturally at 2^OFS_W; the sum wraps at 2^32.
   assign m_wb_adr_o = adr + 32'(ofs);
   assign m_wb_cyc_o = cyc;
   assign m_wb_stb_o = cyc;
   assign m_wb_we_o  = cyc;
   assign m_wb_sel_o = 4'hF;

endmodule
